// File: rtl/bus_valid_pkg.sv
// Shared types and helpers for the bus valid generator.
//   state_t  : burst FSM state encoding (IDLE / SEND / GAP)
//   ch_width : width of the channel id for a given channel count (min 1)
package bus_valid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic int ch_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bus_gap_cnt.sv
// Inter-burst idle gap timer.
//   clk, rst_n : clock, async active-low reset
//   load       : reload the counter at the start of a gap
//   dec        : count down one gap cycle
//   done       : current cycle is the final gap cycle
// The counter is loaded with GAP_CYC-1, so a gap lasts exactly GAP_CYC cycles
// including the one in which done is high. With GAP_CYC==0 no gap is ever
// entered and the block reduces to a constant.
module bus_gap_cnt #(
  parameter int GAP_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  generate
    if (GAP_CYC == 0) begin : g_tie
      logic unused_tie;
      assign unused_tie = ^{clk, rst_n, load, dec};
      assign done = 1'b1;
    end else begin : g_cnt
      localparam int CW = (GAP_CYC <= 1) ? 1 : $clog2(GAP_CYC);
      localparam logic [CW-1:0] LOAD_VAL = CW'(GAP_CYC - 1);

      logic [CW-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (load) begin
          cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
          cnt <= cnt - 1'b1;
        end
      end

      assign done = (cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/bus_valid_gen.sv
// Burst traffic source: sequence-numbered data words with valid/last under
// ready backpressure, channels served round-robin, programmable idle gap.
//   clk, rst_n : clock, async active-low reset
//   en         : start / continue generating bursts (checked at burst boundary)
//   ready      : downstream accepts the beat when valid && ready
//   valid      : beat present
//   data       : {ch_id, seq}
//   last       : final beat of the burst
//   ch_id      : channel of the current burst
//   busy       : FSM not idle
//   burst_cnt  : completed bursts, wraps at 16 bits
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no traffic; en starts a burst on the next cycle
// SEND    | valid high, one beat offered per cycle until the last is taken
// GAP     | valid low for GAP_CYC cycles, then en picks SEND or IDLE
module bus_valid_gen
  import bus_valid_pkg::*;
#(
  parameter int  DATA_W    = 16,
  parameter int  BURST_LEN = 8,
  parameter int  GAP_CYC   = 4,
  parameter int  CH_NUM    = 4,
  localparam int CH_W      = ch_width(CH_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic [CH_W-1:0]   ch_id,
  output logic              busy,
  output logic [15:0]       burst_cnt
);

  localparam int SEQ_W  = DATA_W - CH_W;
  localparam int BEAT_W = (BURST_LEN <= 1) ? 1 : $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CH_NUM - 1);

  state_t             state, state_n;
  logic [SEQ_W-1:0]   seq, seq_n;
  logic [BEAT_W-1:0]  beat, beat_n;
  logic [CH_W-1:0]    ch, ch_n;
  logic [15:0]        bcnt, bcnt_n;
  logic               valid_r, last_r, busy_r;
  logic               gap_load, gap_dec, gap_done;
  logic               accept;

  bus_gap_cnt #(
    .GAP_CYC(GAP_CYC)
  ) u_gap (
    .clk  (clk),
    .rst_n(rst_n),
    .load (gap_load),
    .dec  (gap_dec),
    .done (gap_done)
  );

  assign accept = valid_r && ready;

  always_comb begin
    state_n  = state;
    seq_n    = seq;
    beat_n   = beat;
    ch_n     = ch;
    bcnt_n   = bcnt;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_n = ST_SEND;
      end
      ST_SEND: begin
        if (accept) begin
          seq_n = seq + 1'b1;
          if (beat == BEAT_LAST) begin
            beat_n = '0;
            ch_n   = (ch == CH_LAST) ? '0 : ch + 1'b1;
            bcnt_n = bcnt + 16'd1;
            if (GAP_CYC > 0) begin
              state_n  = ST_GAP;
              gap_load = 1'b1;
            end else if (!en) begin
              state_n = ST_IDLE;
            end
          end else begin
            beat_n = beat + 1'b1;
          end
        end
      end
      ST_GAP: begin
        gap_dec = 1'b1;
        // Only en on the final gap cycle decides whether traffic resumes.
        if (gap_done) state_n = en ? ST_SEND : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output flags are computed from next-state values so every port comes
  // straight from a flop while still lining up with the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      seq     <= '0;
      beat    <= '0;
      ch      <= '0;
      bcnt    <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state   <= state_n;
      seq     <= seq_n;
      beat    <= beat_n;
      ch      <= ch_n;
      bcnt    <= bcnt_n;
      valid_r <= (state_n == ST_SEND);
      last_r  <= (state_n == ST_SEND) && (beat_n == BEAT_LAST);
      busy_r  <= (state_n != ST_IDLE);
    end
  end

  assign valid     = valid_r;
  assign last      = last_r;
  assign busy      = busy_r;
  assign data      = {ch, seq};
  assign ch_id     = ch;
  assign burst_cnt = bcnt;

endmodule
